pe_pipe_elastic: RTL and testbench
==================================

// Module: pe_pipe_elastic
// PURPOSE
//   Parametrised elastic pipeline: DEPTH register stages of WIDTH-bit data with
//   valid/ready handshake on both sides, bubble collapsing, synchronous flush and
//   occupancy count. Generalises the single pipe register between PE core
//   sub-units; DEPTH=1 with out_ready tied high behaves as a plain 1-cycle register.
// PARAMETERS
//   WIDTH  32  data width in bits (>=1)
//   DEPTH  2   number of register stages (>=1); no-stall latency in cycles
//   CNT_W  $clog2(DEPTH+1)  occupancy width (localparam, not overridable)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      pipeline accepts in_data this cycle
//   in_data    in   WIDTH  upstream word
//   out_valid  out  1      last stage holds a valid word
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  word in last stage
//   flush      in   1      discard all in-flight words
//   occupancy  out  CNT_W  number of valid stages
// BEHAVIOUR
//   - State: per stage k (0..DEPTH-1) valid bit v[k] and data d[k]; stage DEPTH-1
//     drives out_valid=v[DEPTH-1], out_data=d[DEPTH-1]. Stage 0 takes the input.
//   - Reset (rst=1 at edge): all v=0, all d=0, occupancy=0 -> out_valid=0,
//     out_data=0. Reset wins over flush and all traffic; in-flight words are lost.
//   - Advance chain (combinational): adv[DEPTH-1] = out_ready | ~v[DEPTH-1];
//     adv[k] = adv[k+1] | ~v[k]. in_ready = adv[0] & ~flush & ~rst.
//   - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//   - Normal edge: for each k with adv[k]: v[k] <= (k==0 ? accept : v[k-1]);
//     d[k] loads upstream data only when upstream valid, else holds.
//     Stages with adv[k]=0 hold v and d.
//   - Bubble collapsing: an empty stage always accepts even if the stage below
//     stalls; words compact toward the output while out_ready=0.
//   - Latency: word accepted in cycle N appears with out_valid=1 in cycle
//     N+DEPTH when no stall occurs. Throughput 1 word/cycle, including when full
//     with out_ready=1 (in_ready stays 1).
//   - out_data/out_valid stable while out_valid=1 & out_ready=0.
//   - Ordering strictly FIFO; no word duplicated or dropped except by flush/rst.
//   - occupancy: register, +1 on accept, -1 on emit, unchanged if both;
//     range 0..DEPTH; equals popcount(v) at all times.
//   - Flush (flush=1, rst=0 at edge): all v <= 0, occupancy <= 0, d held.
//     in_ready=0 during flush so input is never accepted. out_valid is not
//     gated in the flush cycle; if out_ready=1 that emit completes, else the
//     word is discarded.
//   - in_ready is combinational from out_ready (ready chain); no reg slice.
// TESTING
//   T1 DEPTH=3,WIDTH=32: reset, in 42 in cycle 0, out_ready=1 -> out_valid=1,
//      out_data=42 in cycle 3 only; occupancy=1 cycles 1-3, 0 after.
//   T2 Stream 1..10 back-to-back, out_ready=1 -> out_data 1..10 on consecutive
//      cycles from cycle 3; in_ready never 0; occupancy steady at 3.
//   T3 out_ready=0, offer 1..5 -> 3 accepted, in_ready=0, occupancy=3,
//      out_data=1 held; out_ready=1 -> outputs 1,2,3,4,5 in order, none lost.
//   T4 out_ready=0, in_valid every other cycle (7,8,9) -> bubbles collapse,
//      occupancy=3 after third accept, in_ready=0 thereafter.
//   T5 occupancy=2 with flush=1 and in_valid=1 (data 99) same cycle -> next
//      cycle occupancy=0, out_valid=0; 99 never emitted; traffic resumes next.
//   T6 rst=1 mid-stream with occupancy=3 -> next cycle all outputs 0; DEPTH=1
//      variant: in 42 -> out_data=42 after exactly one clk.

Source files
------------

// File: rtl/pe_pipe_elastic.sv
// pe_pipe_elastic: DEPTH-stage elastic pipeline with a valid/ready handshake
// on both sides, bubble collapsing, synchronous flush and an occupancy count.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous reset, active-high; clears valids, data and count
//   in_valid_i   upstream word valid
//   in_ready_o   pipeline accepts in_data_i this cycle
//   in_data_i    upstream word
//   out_valid_o  last stage holds a valid word
//   out_ready_i  downstream accepts out_data_o this cycle
//   out_data_o   word held in the last stage
//   flush_i      discard every in-flight word; data registers keep their value
//   occupancy_o  number of valid stages (0..DEPTH)

// One stage of the pipeline: a valid bit plus a data word.
module pe_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             adv_i,      // this stage may take the upstream slot
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (adv_i) begin
            vld_q <= up_vld_i;
            // Data only moves with a real word, so an idle stage keeps its
            // last value instead of picking up upstream garbage.
            if (up_vld_i) dat_q <= up_dat_i;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
endmodule

module pe_pipe_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_data_o,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            up_vld;
    logic [DEPTH-1:0][WIDTH-1:0] up_dat;
    logic                        accept;
    logic                        emit;
    logic [CNT_W-1:0]            occ_q, occ_d;

    // Ready chain: a stage can move if the stage after it moves or it is
    // empty, so bubbles are squeezed out while the output stalls.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready_i | ~vld_pipe[DEPTH-1];
        for (int k = DEPTH-2; k >= 0; k--)
            adv[k] = adv[k+1] | ~vld_pipe[k];
    end

    assign in_ready_o  = adv[0] & ~flush_i & ~rst_i;
    assign accept      = in_valid_i & in_ready_o;
    assign emit        = out_valid_o & out_ready_i;
    assign out_valid_o = vld_pipe[DEPTH-1];
    assign out_data_o  = dat_pipe[DEPTH-1];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign up_vld[k] = accept;
                assign up_dat[k] = in_data_i;
            end else begin : g_body
                assign up_vld[k] = vld_pipe[k-1];
                assign up_dat[k] = dat_pipe[k-1];
            end

            pe_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .flush_i  (flush_i),
                .adv_i    (adv[k]),
                .up_vld_i (up_vld[k]),
                .up_dat_i (up_dat[k]),
                .vld_o    (vld_pipe[k]),
                .dat_o    (dat_pipe[k])
            );
        end
    endgenerate

    // Counter tracks popcount of the valid bits without an adder tree.
    always_comb begin
        occ_d = occ_q;
        if (accept && !emit)      occ_d = occ_q + CNT_W'(1);
        else if (!accept && emit) occ_d = occ_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) occ_q <= '0;
        else                  occ_q <= occ_d;
    end

    assign occupancy_o = occ_q;
endmodule

// File: tb/tb_pe_pipe_elastic.sv
// Directed bench for pe_pipe_elastic: a DEPTH=3 instance driven from a
// vector table plus hand-written sequences, and a DEPTH=1 instance checked
// as a plain one-cycle register.
module tb_pe_pipe_elastic;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv, fl, ordy;
    logic [31:0] id;
    logic        ir, ov;
    logic [31:0] od;
    logic [1:0]  occ;

    logic        iv1;
    logic [31:0] id1;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [0:0]  occ1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_pipe_elastic #(.WIDTH(32), .DEPTH(3)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(ir),
        .in_data_i(id), .out_valid_o(ov), .out_ready_i(ordy),
        .out_data_o(od), .flush_i(fl), .occupancy_o(occ)
    );

    pe_pipe_elastic #(.WIDTH(32), .DEPTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1),
        .in_data_i(id1), .out_valid_o(ov1), .out_ready_i(1'b1),
        .out_data_o(od1), .flush_i(1'b0), .occupancy_o(occ1)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic o, logic f,
                                logic eir, logic eov, logic [31:0] eod, logic [1:0] eocc);
        vec_t t;
        t.rst = r; t.iv = v; t.id = d; t.ordy = o; t.fl = f;
        t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_occ = eocc;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1; iv = 1'b0; id = '0; ordy = 1'b0; fl = 1'b0;
        iv1 = 1'b0; id1 = '0;

        // Vector table. Each row: inputs for the cycle, then the outputs
        // expected during that cycle (state before the following edge).
        // T1: single word 42, visible in the 4th cycle only.
        tbl.push_back(mk(0,1,42,1,0, 1,0, 0,0));
        tbl.push_back(mk(0,0, 0,1,0, 1,0, 0,1));
        tbl.push_back(mk(0,0, 0,1,0, 1,0, 0,1));
        tbl.push_back(mk(0,0, 0,1,0, 1,1,42,1));
        tbl.push_back(mk(0,0, 0,1,0, 1,0,42,0));
        // T2: stream 1..10 back-to-back, then drain.
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0,1,k,1,0, 1, (k >= 4), (k >= 4) ? k-3 : 42,
                             (k >= 4) ? 3 : k-1));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 8,3));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 9,2));
        tbl.push_back(mk(0,0,0,1,0, 1,1,10,1));
        // T3: stall with 1..5 offered; only three fit, then release.
        tbl.push_back(mk(0,1,1,0,0, 1,0,10,0));
        tbl.push_back(mk(0,1,2,0,0, 1,0,10,1));
        tbl.push_back(mk(0,1,3,0,0, 1,0,10,2));
        tbl.push_back(mk(0,1,4,0,0, 0,1, 1,3));
        tbl.push_back(mk(0,1,4,0,0, 0,1, 1,3));
        tbl.push_back(mk(0,1,4,1,0, 1,1, 1,3));
        tbl.push_back(mk(0,1,5,1,0, 1,1, 2,3));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 3,3));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 4,2));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 5,1));
        // T4: stalled output, words every other cycle; bubbles collapse.
        tbl.push_back(mk(0,1,7,0,0, 1,0, 5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0, 5,1));
        tbl.push_back(mk(0,1,8,0,0, 1,0, 5,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1, 7,2));
        tbl.push_back(mk(0,1,9,0,0, 1,1, 7,2));
        tbl.push_back(mk(0,0,0,0,0, 0,1, 7,3));
        tbl.push_back(mk(0,1,10,0,0,0,1, 7,3));
        tbl.push_back(mk(0,0,0,1,0, 1,1, 7,3));
        // T5: flush at occupancy 2 with 99 offered; 99 must never appear.
        tbl.push_back(mk(0,1,99,0,1, 0,1, 8,2));
        tbl.push_back(mk(0,0, 0,0,0, 1,0, 8,0));
        tbl.push_back(mk(0,1,50,1,0, 1,0, 8,0));
        tbl.push_back(mk(0,1,51,1,0, 1,0, 8,1));
        tbl.push_back(mk(0,0, 0,1,0, 1,0, 8,2));
        tbl.push_back(mk(0,0, 0,1,0, 1,1,50,2));
        tbl.push_back(mk(0,0, 0,1,0, 1,1,51,1));
        tbl.push_back(mk(0,0, 0,1,0, 1,0,51,0));
        // T6: fill to 3, then reset mid-stream.
        tbl.push_back(mk(0,1,61,0,0, 1,0,51,0));
        tbl.push_back(mk(0,1,62,0,0, 1,0,51,1));
        tbl.push_back(mk(0,1,63,0,0, 1,0,51,2));
        tbl.push_back(mk(1,1,64,1,0, 0,1,61,3));
        tbl.push_back(mk(0,0, 0,0,0, 1,0, 0,0));

        // Reset both instances.
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",  0, ir,   0);
        chk("rst out_valid", 0, ov,   0);
        chk("rst out_data",  0, od,   0);
        chk("rst occupancy", 0, occ,  0);
        chk("d1 rst out_valid", 0, ov1, 0);
        chk("d1 rst out_data",  0, od1, 0);
        chk("d1 rst occupancy", 0, occ1, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; iv = tbl[i].iv; id = tbl[i].id;
            ordy = tbl[i].ordy; fl = tbl[i].fl;
            #2;
            chk("in_ready",  i, ir,  tbl[i].e_ir);
            chk("out_valid", i, ov,  tbl[i].e_ov);
            chk("out_data",  i, od,  tbl[i].e_od);
            chk("occupancy", i, occ, tbl[i].e_occ);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; iv = 1'b0; ordy = 1'b0; fl = 1'b0;

        // Latency measured with a bounded wait: 77 in, expect 3 cycles.
        iv = 1'b1; id = 77; ordy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            if (ov) lat = n;
            else begin
                @(posedge clk); #1;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL latency timeout: got no out_valid expected within 10 cycles");
        end else begin
            chk("latency", 0, lat, 3);
            chk("latency data", 0, od, 77);
        end
        @(posedge clk); #1;
        chk("latency drain occ", 0, occ, 0);

        // DEPTH=1 variant: plain one-cycle register.
        iv1 = 1'b1; id1 = 42;
        #2;
        chk("d1 in_ready", 0, ir1, 1);
        @(posedge clk); #1;
        chk("d1 out_valid", 0, ov1, 1);
        chk("d1 out_data",  0, od1, 42);
        chk("d1 occupancy", 0, occ1, 1);
        id1 = 43;
        @(posedge clk); #1;
        chk("d1 out_data",  1, od1, 43);
        iv1 = 1'b0;
        @(posedge clk); #1;
        chk("d1 out_valid", 1, ov1, 0);
        chk("d1 occupancy", 1, occ1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
